// File: rtl/ca_row_renderer_if.sv
// Pixel timing bus from the VGA sync generator to pixel-stage consumers.
// Carries pixel enable, visible-area flag and the raster counters.
// master = sync generator side, slave = consumer side.
interface ca_row_renderer_if;
  logic        pixel_tick;
  logic        video_on;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;

  modport master (output pixel_tick, output video_on, output pixel_x, output pixel_y);
  modport slave  (input  pixel_tick, input  video_on, input  pixel_x, input  pixel_y);
endinterface

// File: rtl/ca_row_renderer.sv
// Renders a 1-D elementary cellular automaton, one generation per CELL_PX-pixel band.
// Latency: rgb is registered, 1 clk after the raster inputs; next generation takes CELLS+1 clk.
// Backpressure: none; the raster bus is free-running and the engine runs inside hblank.
module ca_row_renderer #(
  parameter int          CELLS   = 80,
  parameter int          CELL_PX = 8,
  parameter int          HD      = 640,
  parameter int          VD      = 480,
  parameter logic [7:0]  RULE    = 8'd30,
  parameter logic [11:0] FG_RGB  = 12'hFFF,
  parameter logic [11:0] BG_RGB  = 12'h000
) (
  input  logic                clk,
  input  logic                reset_n,
  ca_row_renderer_if.slave    pix,
  input  logic [7:0]          rule_in,
  output logic [11:0]         rgb,
  output logic                busy
);

  localparam int IDXW = $clog2(CELLS);
  localparam int PXW  = $clog2(CELL_PX);

  localparam logic [CELLS-1:0] SEED      = {{(CELLS-1){1'b0}}, 1'b1} << (CELLS / 2);
  localparam logic [10:0]      HD_X      = 11'(HD);
  localparam logic [10:0]      VD_Y      = 11'(VD);
  localparam logic [10:0]      LAST_Y    = 11'(VD - 1);
  localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(CELLS - 1);
  localparam logic [PXW-1:0]   BAND_LAST = PXW'(CELL_PX - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [CELLS-1:0] cur_row_q, cur_row_d;
  logic [CELLS-1:0] nxt_row_q, nxt_row_d;
  logic [7:0]       rule_q, rule_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             busy_q, busy_d;

  logic             reload;
  logic             start;
  logic [IDXW-1:0]  l_idx;
  logic [IDXW-1:0]  r_idx;
  logic [2:0]       nbhd;
  logic             new_cell;
  logic             in_vis;
  logic [IDXW-1:0]  col;
  logic             cell_on;

  // Raster events: frame reload in vblank, generation start at the end of a band's last line.
  always_comb begin
    reload = pix.pixel_tick && (pix.pixel_x == '0) && (pix.pixel_y == VD_Y);
    start  = pix.pixel_tick && (pix.pixel_x == HD_X) && (pix.pixel_y < LAST_Y) &&
             (pix.pixel_y[PXW-1:0] == BAND_LAST);
  end

  // Circular neighbourhood of the cell being computed and its rule lookup.
  always_comb begin
    l_idx    = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
    r_idx    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    nbhd     = {cur_row_q[l_idx], cur_row_q[idx_q], cur_row_q[r_idx]};
    new_cell = rule_q[nbhd];
  end

  // Generation engine: serial compute into nxt_row, single-cycle commit; reload wins.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cur_row_d = cur_row_q;
    nxt_row_d = nxt_row_q;
    rule_d    = rule_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COMPUTE;
          idx_d   = '0;
        end
      end
      COMPUTE: begin
        nxt_row_d[idx_q] = new_cell;
        if (idx_q == LAST_IDX) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      COMMIT: begin
        cur_row_d = nxt_row_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reload) begin
      cur_row_d = SEED;
      rule_d    = rule_in;
      state_d   = IDLE;
      idx_d     = '0;
    end
    busy_d = (state_d != IDLE);
  end

  // Pixel colour lookup; columns past the visible width never index the row.
  always_comb begin
    in_vis  = (pix.pixel_x < HD_X);
    col     = in_vis ? IDXW'(pix.pixel_x >> PXW) : '0;
    cell_on = in_vis && cur_row_q[col];
    rgb_d   = (pix.video_on && cell_on) ? FG_RGB : BG_RGB;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cur_row_q <= SEED;
      nxt_row_q <= SEED;
      rule_q    <= RULE;
      rgb_q     <= 12'h000;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cur_row_q <= cur_row_d;
      nxt_row_q <= nxt_row_d;
      rule_q    <= rule_d;
      rgb_q     <= rgb_d;
      busy_q    <= busy_d;
    end
  end

  assign rgb  = rgb_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_ca_row_renderer.sv
// Bench for ca_row_renderer: drives a compressed raster and checks every cell of every band.
// Expected colours come from a direct cellular-automaton model of the rule table.
// Also checks busy duration, reload priority, async reset and mid-frame rule changes.
module tb_ca_row_renderer;
  localparam int          CELLS   = 80;
  localparam int          CELL_PX = 8;
  localparam int          HD      = 640;
  localparam int          VD      = 480;
  localparam int          BANDS   = VD / CELL_PX;
  localparam logic [11:0] FG      = 12'hFFF;
  localparam logic [11:0] BG      = 12'h000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rule_in;
  logic [11:0] rgb;
  logic        busy;

  int checks = 0;
  int passed = 0;

  bit         model_row[CELLS];
  logic [7:0] model_rule;

  ca_row_renderer_if pix();

  ca_row_renderer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pix     (pix),
    .rule_in (rule_in),
    .rgb     (rgb),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic model_seed();
    for (int i = 0; i < CELLS; i++) model_row[i] = (i == CELLS / 2);
  endtask

  task automatic model_step();
    bit nxt[CELLS];
    for (int i = 0; i < CELLS; i++) begin
      int l, c, r;
      l = model_row[(i + CELLS - 1) % CELLS];
      c = model_row[i];
      r = model_row[(i + 1) % CELLS];
      nxt[i] = model_rule[l * 4 + c * 2 + r];
    end
    model_row = nxt;
  endtask

  task automatic step(input bit tick, input bit von, input int x, input int y);
    pix.pixel_tick = tick;
    pix.video_on   = von;
    pix.pixel_x    = 11'(x);
    pix.pixel_y    = 11'(y);
    @(posedge clk);
    #1;
  endtask

  // One band: launch the engine, sample every cell while it computes, then verify busy length.
  task automatic run_band(input int b);
    int  y;
    int  busy_cnt;
    int  exp_cnt;
    bit  last;
    y        = b * CELL_PX + CELL_PX - 1;
    busy_cnt = 0;
    last     = (b == BANDS - 1);
    exp_cnt  = last ? 0 : CELLS + 1;

    step(1'b0, 1'b0, HD, y);
    checks++;
    if (busy !== 1'b0) $display("FAIL no_start_without_tick band%0d: busy=%b want 0", b, busy);
    else passed++;

    step(1'b1, 1'b0, HD, y);
    busy_cnt += int'(busy);

    for (int c = 0; c < CELLS; c++) begin
      bit          von;
      int          x;
      logic [11:0] exp;
      x   = c * CELL_PX + int'($urandom_range(0, CELL_PX - 1));
      von = ($urandom_range(0, 7) != 0);
      step(bit'(c % 2), von, x, y);
      busy_cnt += int'(busy);
      exp = (von && model_row[c]) ? FG : BG;
      checks++;
      if (rgb !== exp) $display("FAIL rgb band%0d cell%0d von%0d: got %h want %h", b, c, von, rgb, exp);
      else passed++;
    end

    step(1'b1, 1'b1, HD + 1 + int'($urandom_range(0, 150)), y);
    busy_cnt += int'(busy);
    checks++;
    if (rgb !== BG) $display("FAIL rgb_offscreen band%0d: got %h want %h", b, rgb, BG);
    else passed++;

    step(1'b0, 1'b0, HD + 200, y);
    busy_cnt += int'(busy);
    checks++;
    if (busy_cnt !== exp_cnt) $display("FAIL busy_len band%0d: got %0d want %0d", b, busy_cnt, exp_cnt);
    else passed++;

    if (!last) model_step();
  endtask

  task automatic run_frame(input int nbands, input bit mid_change, input logic [7:0] mid_rule);
    for (int b = 0; b < nbands; b++) begin
      if (mid_change && b == 5) rule_in = mid_rule;
      run_band(b);
    end
  endtask

  task automatic do_reload(input logic [7:0] r);
    rule_in = r;
    step(1'b1, 1'b0, 0, VD);
    model_seed();
    model_rule = r;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    rule_in        = 8'd30;
    pix.pixel_tick = 1'b0;
    pix.video_on   = 1'b0;
    pix.pixel_x    = '0;
    pix.pixel_y    = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rgb !== 12'h000) $display("FAIL reset_rgb: got %h want 000", rgb);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else passed++;
    reset_n = 1'b1;
    model_seed();
    model_rule = 8'd30;
  endtask

  task automatic test_default_rule();
    run_frame(BANDS, 1'b0, 8'h00);
  endtask

  task automatic test_rule90();
    do_reload(8'd90);
    run_frame(BANDS, 1'b0, 8'h00);
  endtask

  task automatic test_wrap();
    do_reload(8'hAA);
    run_frame(BANDS, 1'b0, 8'h00);
  endtask

  task automatic test_rule_midframe();
    do_reload(8'h00);
    run_frame(BANDS, 1'b1, 8'hFF);
    do_reload(8'hFF);
    run_frame(BANDS, 1'b0, 8'h00);
  endtask

  task automatic test_reload_priority();
    do_reload(8'd30);
    run_frame(3, 1'b0, 8'h00);
    step(1'b1, 1'b0, HD, 3 * CELL_PX + CELL_PX - 1);
    repeat (5) step(1'b0, 1'b1, 100, 3 * CELL_PX + CELL_PX - 1);
    do_reload(8'd90);
    checks++;
    if (busy !== 1'b0) $display("FAIL reload_abort_busy: got %b want 0", busy);
    else passed++;
    run_frame(4, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] r;
    r = 8'($urandom_range(0, 255));
    do_reload(r);
    run_frame(BANDS, 1'b1, 8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset_midcompute();
    do_reload(8'd90);
    run_frame(10, 1'b0, 8'h00);
    step(1'b1, 1'b0, HD, 10 * CELL_PX + CELL_PX - 1);
    repeat (6) step(1'b0, 1'b1, 40 * CELL_PX, 10 * CELL_PX + CELL_PX - 1);
    rule_in = 8'h5A;
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) $display("FAIL async_reset_busy: got %b want 0", busy);
    else passed++;
    checks++;
    if (rgb !== 12'h000) $display("FAIL async_reset_rgb: got %h want 000", rgb);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_seed();
    model_rule = 8'd30;
    run_frame(BANDS, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_default_rule();
    test_rule90();
    test_wrap();
    test_rule_midframe();
    test_reload_priority();
    test_random();
    test_reset_midcompute();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
